// File: rtl/sync_mem_pkg.sv
// Purpose : shared types and helpers for the dual-port synchronous memory.
// Latency : n/a (constants, types and pure functions only).
// Backpr. : n/a.
// Contents: BYTE_W, MAX_DATA_W (widest supported word), mem_resp_t {data, err},
//           word_idx(addr, off), merge_bytes(old_w, wdata, mask).
package sync_mem_pkg;

  localparam int BYTE_W     = 8;
  // Word widths up to MAX_DATA_W are supported; narrower words are zero-extended
  // into the shared response type.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_BYTES  = MAX_DATA_W / BYTE_W;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  err;
  } mem_resp_t;

  // Byte address to word index; off = log2(bytes per word).
  function automatic logic [63:0] word_idx(input logic [63:0] addr, input int unsigned off);
    return addr >> off;
  endfunction

  // Replace the bytes of old_w selected by mask with the matching bytes of wdata.
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(input logic [MAX_DATA_W-1:0] old_w,
                                                        input logic [MAX_DATA_W-1:0] wdata,
                                                        input logic [MAX_BYTES-1:0]  mask);
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (mask[b]) r[b*BYTE_W +: BYTE_W] = wdata[b*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Purpose : READ_LAT-deep valid/ready response pipeline for one memory port.
// Latency : READ_LAT cycles from in_valid&in_ready to out_valid when unblocked.
// Backpr. : a stage advances only when the next stage is empty or draining;
//           the output stage holds data/err stable while out_ready=0.
// Ports   : clk, rst_n (sync, active low); in_valid/in_ready/in_resp (request side);
//           out_valid/out_ready/out_resp (response side).
module mem_resp_pipe
  import sync_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  mem_resp_t in_resp,
  output logic      out_valid,
  input  logic      out_ready,
  output mem_resp_t out_resp
);

  logic [READ_LAT-1:0] st_vld;
  logic [READ_LAT-1:0] st_err;
  logic [READ_LAT-1:0] take;
  logic [DATA_W-1:0]   st_dat [READ_LAT];

  // take[k]: stage k may load this cycle. True if it, or any stage after it,
  // is empty, or if the output is being consumed.
  always_comb begin : take_logic
    logic acc;
    acc  = out_ready;
    take = '0;
    for (int k = READ_LAT - 1; k >= 0; k--) begin
      acc     = acc | ~st_vld[k];
      take[k] = acc;
    end
  end

  assign in_ready = rst_n & take[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_vld <= '0;
      st_err <= '0;
      for (int k = 0; k < READ_LAT; k++) st_dat[k] <= '0;
    end else begin
      if (take[0]) begin
        st_vld[0] <= in_valid;
        st_dat[0] <= in_resp.data[DATA_W-1:0];
        st_err[0] <= in_resp.err;
      end
      for (int k = 1; k < READ_LAT; k++) begin
        if (take[k]) begin
          st_vld[k] <= st_vld[k-1];
          st_dat[k] <= st_dat[k-1];
          st_err[k] <= st_err[k-1];
        end
      end
    end
  end

  // Outputs are forced quiet while reset is asserted, not just after the reset edge.
  assign out_valid = rst_n & st_vld[READ_LAT-1];

  always_comb begin
    out_resp = '0;
    if (rst_n) begin
      out_resp.data = MAX_DATA_W'(st_dat[READ_LAT-1]);
      out_resp.err  = st_err[READ_LAT-1];
    end
  end

  logic unused_ok;
  assign unused_ok = ^in_resp.data;

endmodule

// File: rtl/dual_port_sync_mem.sv
// Purpose : unified I/D memory; port I read-only fetch, port D byte-masked load/store.
// Latency : READ_LAT cycles accept-to-resp_valid per port, one request per cycle.
// Backpr. : each port stalls its own request side when its response pipe is full;
//           responses are held in order under resp_ready=0. Ports never stall each other.
// Ports   : clk, rst_n; i_req_{valid,ready,addr}, i_resp_{valid,ready,data,err};
//           d_req_{valid,ready,we,addr,wdata,mask}, d_resp_{valid,ready,rdata,err}.
// Config  : MEM_WR_FWD_EN defined -> same-cycle store/fetch to one word returns the
//           merged (write-first) word to the fetch; undefined -> read-first.
//           INIT_HEX_FILE names a preload image for external preload flows; the array
//           itself has no reset or load logic.
module dual_port_sync_mem
  import sync_mem_pkg::*;
#(
  parameter int    DATA_W        = 32,
  parameter int    ADDR_W        = 32,
  parameter int    DEPTH_WORDS   = 32768,
  parameter int    READ_LAT      = 1,
  parameter string INIT_HEX_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 i_req_ready,
  input  logic [ADDR_W-1:0]    i_req_addr,
  output logic                 i_resp_valid,
  input  logic                 i_resp_ready,
  output logic [DATA_W-1:0]    i_resp_data,
  output logic                 i_resp_err,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_req_we,
  input  logic [ADDR_W-1:0]    d_req_addr,
  input  logic [DATA_W-1:0]    d_req_wdata,
  input  logic [DATA_W/8-1:0]  d_req_mask,
  output logic                 d_resp_valid,
  input  logic                 d_resp_ready,
  output logic [DATA_W-1:0]    d_resp_rdata,
  output logic                 d_resp_err
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int OFF    = $clog2(NBYTES);
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit unused_has_image = (INIT_HEX_FILE != "");

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [63:0]           i_idx, d_idx;
  logic                  i_fault, d_fault;
  logic                  i_fire, d_fire, d_store;
  logic [DATA_W-1:0]     i_word, d_word, d_new;
  logic [MAX_DATA_W-1:0] d_merge_full;
  mem_resp_t             i_rsp_in, d_rsp_in, i_rsp_out, d_rsp_out;

  assign i_idx   = word_idx(64'(i_req_addr), OFF);
  assign d_idx   = word_idx(64'(d_req_addr), OFF);
  assign i_fault = (i_idx >= 64'(DEPTH_WORDS));
  assign d_fault = (d_idx >= 64'(DEPTH_WORDS));

  assign i_fire  = i_req_valid & i_req_ready;
  assign d_fire  = d_req_valid & d_req_ready;
  // A faulting store is still accepted and answered, but never reaches the array.
  assign d_store = d_fire & d_req_we & ~d_fault;

  // Array reads are combinational and captured by the pipes on the accepting
  // edge, so they see the contents from before any same-edge store.
  assign i_word = mem[i_idx[IDX_W-1:0]];
  assign d_word = mem[d_idx[IDX_W-1:0]];

  assign d_merge_full = merge_bytes(MAX_DATA_W'(d_word), MAX_DATA_W'(d_req_wdata),
                                    MAX_BYTES'(d_req_mask));
  assign d_new        = d_merge_full[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (d_store) mem[d_idx[IDX_W-1:0]] <= d_new;
  end

  always_comb begin
    i_rsp_in     = '0;
    i_rsp_in.err = i_fault;
    if (!i_fault) begin
`ifdef MEM_WR_FWD_EN
      if (d_store && (d_idx == i_idx)) i_rsp_in.data = MAX_DATA_W'(d_new);
      else                             i_rsp_in.data = MAX_DATA_W'(i_word);
`else
      i_rsp_in.data = MAX_DATA_W'(i_word);
`endif
    end
  end

  // Stores answer with zero data; faults answer with zero data and err=1.
  always_comb begin
    d_rsp_in     = '0;
    d_rsp_in.err = d_fault;
    if (!d_fault && !d_req_we) d_rsp_in.data = MAX_DATA_W'(d_word);
  end

  mem_resp_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_i_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (i_req_valid),
    .in_ready  (i_req_ready),
    .in_resp   (i_rsp_in),
    .out_valid (i_resp_valid),
    .out_ready (i_resp_ready),
    .out_resp  (i_rsp_out)
  );

  mem_resp_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_d_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d_req_valid),
    .in_ready  (d_req_ready),
    .in_resp   (d_rsp_in),
    .out_valid (d_resp_valid),
    .out_ready (d_resp_ready),
    .out_resp  (d_rsp_out)
  );

  assign i_resp_data  = i_rsp_out.data[DATA_W-1:0];
  assign i_resp_err   = i_rsp_out.err;
  assign d_resp_rdata = d_rsp_out.data[DATA_W-1:0];
  assign d_resp_err   = d_rsp_out.err;

  logic unused_ok;
  assign unused_ok = ^{i_rsp_out.data, d_rsp_out.data, d_merge_full, i_fire, d_fire,
                       unused_has_image};

endmodule
